// File: rtl/lsu_ctrl.sv
// Load/store unit: turns RV32I byte/half/word loads and stores into word-wide
// accesses on a synchronous-write, combinational-read memory port. Sub-word
// stores are done as read-modify-write; misaligned or illegal requests are
// answered with rsp_err and never touch memory.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StRmwWr, StResp} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_data_q, rmw_data_d;

  logic              is_half, is_word, illegal, misaligned, is_err;
  logic [ADDR_W-1:0] aligned_addr;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data, merged;
  logic              we_int;
  logic [DATA_W-1:0] wd_int;

  assign aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign is_half      = (req_funct3[1:0] == 2'b01);
  assign is_word      = (req_funct3[1:0] == 2'b10);

  // Decode legality and alignment of the request presented this cycle.
  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      illegal = (req_funct3 >= 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    is_err     = illegal || misaligned;
  end

  // Pick the addressed lane out of the memory word and extend it.
  always_comb begin
    ld_byte = 8'h00;
    unique case (req_addr[1:0])
      2'b00: ld_byte = mem_rd[7:0];
      2'b01: ld_byte = mem_rd[15:8];
      2'b10: ld_byte = mem_rd[23:16];
      2'b11: ld_byte = mem_rd[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_data = '0;
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rd;
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = '0;
    endcase
  end

  // Splice the sub-word store data into the current memory word.
  always_comb begin
    merged = mem_rd;
    if (is_half) begin
      if (req_addr[1]) merged[31:16] = req_wdata[15:0];
      else             merged[15:0]  = req_wdata[15:0];
    end else begin
      unique case (req_addr[1:0])
        2'b00: merged[7:0]   = req_wdata[7:0];
        2'b01: merged[15:8]  = req_wdata[7:0];
        2'b10: merged[23:16] = req_wdata[7:0];
        2'b11: merged[31:24] = req_wdata[7:0];
        default: merged = mem_rd;
      endcase
    end
  end

  // Next state, response capture and memory-port drive.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    we_int     = 1'b0;
    wd_int     = '0;
    mem_addr   = aligned_addr;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = is_err;
          if (!is_err) begin
            if (!req_we) begin
              rdata_d = ld_data;
            end else if (is_word) begin
              we_int = 1'b1;
              wd_int = req_wdata;
            end else begin
              rmw_addr_d = aligned_addr;
              rmw_data_d = merged;
              state_d    = StRmwWr;
            end
          end
        end
      end
      StRmwWr: begin
        we_int   = 1'b1;
        wd_int   = rmw_data_q;
        mem_addr = rmw_addr_q;
        state_d  = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset kills any pending write at once, not at the next edge.
  assign mem_we    = we_int & rst_n;
  assign mem_wd    = mem_we ? wd_int : '0;
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
    end
  end

endmodule
